// File: rtl/lzc_norm_pipe_pkg.sv
// lzc_norm_pipe_pkg: shared widths, saturation limit and leading-zero count helper
package lzc_norm_pipe_pkg;
  localparam int DATA_W = 64;
  localparam int SAMT_W = 5;
  localparam int TAG_W = 4;
  localparam int LZC_W = 7;
  localparam logic [SAMT_W-1:0] MAX_SAMT = 5'd31;
  function automatic logic [LZC_W-1:0] lzc(input logic [DATA_W-1:0] d);
    lzc = LZC_W'(DATA_W);
    for (int i = 0; i < DATA_W; i++)
      if (d[i]) lzc = LZC_W'(DATA_W - 1 - i);
  endfunction
endpackage

// File: rtl/barrel_shift_left.sv
// barrel_shift_left: combinational logical left shift by i_samt
module barrel_shift_left #(
  parameter int DATA_W = 64,
  parameter int SAMT_W = 5
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [SAMT_W-1:0] i_samt,
  output logic [DATA_W-1:0] o_data
);
  assign o_data = i_data << i_samt;
endmodule

// File: rtl/lzc_norm_pipe.sv
// lzc_norm_pipe: three-stage valid/ready normalizer, shift = min(lzc, 31)
module lzc_norm_pipe
  import lzc_norm_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SAMT_W-1:0] out_samt,
  output logic              out_norm,
  output logic              out_zero,
  output logic [TAG_W-1:0]  out_tag
);
  logic              r_s1_v;
  logic [DATA_W-1:0] r_s1_data;
  logic [TAG_W-1:0]  r_s1_tag;
  logic              r_s2_v;
  logic [DATA_W-1:0] r_s2_data;
  logic [LZC_W-1:0]  r_s2_lzc;
  logic              r_s2_zero;
  logic [TAG_W-1:0]  r_s2_tag;
  logic              w_s3_free;
  logic              w_s2_free;
  logic              w_s1_adv;
  logic              w_s2_adv;
  logic              w_in_xfer;
  logic [SAMT_W-1:0] w_s2_samt;
  logic              w_s2_norm;
  logic [DATA_W-1:0] w_sh_data;
  // a stage is free when empty or when its occupant leaves this cycle
  assign w_s3_free = !out_valid || out_ready;
  assign w_s2_free = !r_s2_v || w_s3_free;
  assign w_s1_adv  = r_s1_v && w_s2_free;
  assign w_s2_adv  = r_s2_v && w_s3_free;
  assign in_ready  = !r_s1_v || w_s2_free;
  assign w_in_xfer = in_valid && in_ready;
  assign w_s2_samt = (r_s2_lzc > LZC_W'(MAX_SAMT)) ? MAX_SAMT : r_s2_lzc[SAMT_W-1:0];
  assign w_s2_norm = (r_s2_lzc <= LZC_W'(MAX_SAMT)) && !r_s2_zero;
  barrel_shift_left #(
    .DATA_W(DATA_W),
    .SAMT_W(SAMT_W)
  ) u_bsl (
    .i_data(r_s2_data),
    .i_samt(w_s2_samt),
    .o_data(w_sh_data)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v    <= 1'b0;
      r_s1_data <= '0;
      r_s1_tag  <= '0;
    end else begin
      if (in_ready) r_s1_v <= in_valid;
      if (w_in_xfer) begin
        r_s1_data <= in_data;
        r_s1_tag  <= in_tag;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_v    <= 1'b0;
      r_s2_data <= '0;
      r_s2_lzc  <= '0;
      r_s2_zero <= 1'b0;
      r_s2_tag  <= '0;
    end else begin
      if (w_s2_free) r_s2_v <= r_s1_v;
      if (w_s1_adv) begin
        r_s2_data <= r_s1_data;
        r_s2_lzc  <= lzc(r_s1_data);
        r_s2_zero <= (r_s1_data == '0);
        r_s2_tag  <= r_s1_tag;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_samt  <= '0;
      out_norm  <= 1'b0;
      out_zero  <= 1'b0;
      out_tag   <= '0;
    end else begin
      if (w_s3_free) out_valid <= r_s2_v;
      if (w_s2_adv) begin
        out_data <= w_sh_data;
        out_samt <= w_s2_samt;
        out_norm <= w_s2_norm;
        out_zero <= r_s2_zero;
        out_tag  <= r_s2_tag;
      end
    end
  end
endmodule

// File: tb/tb_lzc_norm_pipe.sv
// tb_lzc_norm_pipe: directed + random stimulus against an arithmetic scoreboard model
module tb_lzc_norm_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_samt;
  logic        out_norm;
  logic        out_zero;
  logic [3:0]  out_tag;

  typedef struct packed {
    logic [63:0] d;
    logic [4:0]  s;
    logic        n;
    logic        z;
    logic [3:0]  t;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        seen_v;
  logic        seen_rdy;
  logic        hold_pend = 1'b0;
  logic [75:0] held;

  lzc_norm_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_samt(out_samt), .out_norm(out_norm), .out_zero(out_zero), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [63:0] d, input logic [3:0] t);
    logic [63:0] x;
    int lz;
    x = d;
    lz = 0;
    if (d == 64'd0) lz = 64;
    else while (x < 64'h8000_0000_0000_0000) begin
      x = x * 2;
      lz++;
    end
    model.s = (lz > 31) ? 5'd31 : 5'(lz);
    model.d = d << model.s;
    model.n = (lz <= 31) && (d != 64'd0);
    model.z = (d == 64'd0);
    model.t = t;
  endfunction

  function automatic logic [63:0] rnd64();
    if ($urandom_range(0, 7) == 0) return 64'd0;
    return {$urandom, $urandom} >> $urandom_range(0, 63);
  endfunction

  task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    seen_v = out_valid;
    seen_rdy = in_ready;
    if (hold_pend) chk("hold", {out_valid, out_data, out_samt, out_norm, out_zero, out_tag}, held);
    hold_pend = out_valid && !out_ready;
    held = {out_valid, out_data, out_samt, out_norm, out_zero, out_tag};
    if (in_valid && in_ready) q.push_back(model(in_data, in_tag));
    if (out_valid && out_ready) begin
      chk("result_expected", 76'(q.size() != 0), 76'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("out_data", 76'(out_data), 76'(e.d));
        chk("out_samt", 76'(out_samt), 76'(e.s));
        chk("out_norm", 76'(out_norm), 76'(e.n));
        chk("out_zero", 76'(out_zero), 76'(e.z));
        chk("out_tag", 76'(out_tag), 76'(e.t));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [63:0] d, input logic [3:0] t);
    int n;
    in_valid = 1'b1;
    in_data = d;
    in_tag = t;
    tick();
    in_valid = 1'b0;
    in_data = {$urandom, $urandom};
    n = 0;
    do begin
      n++;
      tick();
    end while (!seen_v && n < 10);
    chk("latency", 76'(n), 76'd3);
  endtask

  initial begin
    int nv, first, last;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_tag = '0;
    out_ready = 1'b1;
    #3;
    chk("rst_out_valid", 76'(out_valid), 76'd0);
    chk("rst_out_data", 76'(out_data), 76'd0);
    chk("rst_out_samt", 76'(out_samt), 76'd0);
    chk("rst_out_flags", 76'({out_norm, out_zero}), 76'd0);
    chk("rst_out_tag", 76'(out_tag), 76'd0);
    chk("rst_in_ready", 76'(in_ready), 76'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    send1(64'h0000_0000_0001_0000, 4'd1);
    send1(64'h0000_0000_0000_0001, 4'd2);
    send1(64'h0000_0000_0000_0000, 4'd3);
    send1(64'h8000_0000_0000_0000, 4'd4);
    send1(64'h0000_0001_0000_0000, 4'd5);
    send1(64'h0000_0000_8000_0000, 4'd6);
    send1(64'hFFFF_FFFF_FFFF_FFFF, 4'd7);

    nv = 0;
    first = -1;
    last = -1;
    for (int i = 0; i < 14; i++) begin
      in_valid = (i < 8);
      in_data = rnd64();
      in_tag = 4'(i);
      tick();
      if (seen_v) begin
        nv++;
        if (first < 0) first = i;
        last = i;
      end
    end
    chk("burst_count", 76'(nv), 76'd8);
    chk("burst_contig", 76'(last - first), 76'd7);

    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = rnd64();
      in_tag = 4'(i + 8);
      tick();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_data = rnd64();
      in_tag = 4'(i);
      tick();
      if (i == 3) chk("bp_in_ready", 76'(seen_rdy), 76'd0);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    repeat (10) tick();
    chk("bp_drained", 76'(q.size()), 76'd0);

    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = rnd64();
      in_tag = 4'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();
    chk("rand_drained", 76'(q.size()), 76'd0);

    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = rnd64();
      in_tag = 4'(i + 10);
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 76'(out_valid), 76'd0);
    chk("midrst_in_ready", 76'(in_ready), 76'd1);
    q.delete();
    hold_pend = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (seen_v) nv++;
    end
    chk("no_stale", 76'(nv), 76'd0);
    send1(64'h0000_0000_0000_0F00, 4'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
